// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX path: FSM state encoding, line levels and
// the parity-type encodings also used by the parity stage.
package uart_tx_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Producer-side bundle of the TX framing controller: payload handshake,
// parity input from the parity stage, and the serial line plus BUSY back.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_BIT;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_BIT,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_BIT,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_frame_ctrl_shifter.sv
// Payload load/shift register with bit counter; last_s flags the final data bit.
module uart_tx_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_s,
  input  logic                  shift_s,
  input  logic                  cnt_en_s,
  input  logic [DATA_WIDTH-1:0] data_s,
  output logic                  bit0_s,
  output logic                  last_s
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0]      cnt_r;

  // Load has priority so a back-to-back accept from STOP starts cleanly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (load_s) begin
      shreg_r <= data_s;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (shift_s) begin
        shreg_r <= shreg_r >> 1;
      end else begin
        shreg_r <= shreg_r;
      end
      if (cnt_en_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bit0_s = shreg_r[0];
  assign last_s = (cnt_r == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing FSM: start bit, LSB-first payload, optional parity, stop bit,
// one bit per baud clock, with back-to-back accept from the STOP cycle.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic                  CLK,
  input logic                  RST,
  uart_tx_frame_ctrl_if.slave  bus
);

  tx_state_e state_r;
  logic      tx_out_r;
  logic      busy_r;
  logic      par_en_q_r;
  logic      par_q_r;

  logic      accept_s;
  logic      shift_s;
  logic      cnt_en_s;
  logic      bit0_s;
  logic      last_s;

  // Accept/shift strobes decoded from the current state.
  always_comb begin
    accept_s = 1'b0;
    shift_s  = 1'b0;
    cnt_en_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = bus.DATA_VALID;
      STOP:    accept_s = bus.DATA_VALID;
      START:   shift_s  = 1'b1;
      DATA: begin
        shift_s  = 1'b1;
        cnt_en_s = 1'b1;
      end
      PARITY:  accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
  end

  uart_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .CLK      (CLK),
    .RST      (RST),
    .load_s   (accept_s),
    .shift_s  (shift_s),
    .cnt_en_s (cnt_en_s),
    .data_s   (bus.P_DATA),
    .bit0_s   (bit0_s),
    .last_s   (last_s)
  );

  // Frame sequencer with registered line and BUSY outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      tx_out_r   <= IDLE_LVL;
      busy_r     <= 1'b0;
      par_en_q_r <= 1'b0;
      par_q_r    <= 1'b0;
    end else if (accept_s) begin
      par_en_q_r <= bus.PAR_EN;
      tx_out_r   <= START_LVL;
      busy_r     <= 1'b1;
      state_r    <= START;
    end else begin
      case (state_r)
        IDLE: begin
          tx_out_r <= IDLE_LVL;
          busy_r   <= 1'b0;
        end
        START: begin
          // PAR_BIT here reflects the parity stage's capture at the accept edge.
          par_q_r  <= bus.PAR_BIT;
          tx_out_r <= bit0_s;
          state_r  <= DATA;
        end
        DATA: begin
          if (last_s) begin
            if (par_en_q_r) begin
              tx_out_r <= par_q_r;
              state_r  <= PARITY;
            end else begin
              tx_out_r <= STOP_LVL;
              state_r  <= STOP;
            end
          end else begin
            tx_out_r <= bit0_s;
          end
        end
        PARITY: begin
          tx_out_r <= STOP_LVL;
          state_r  <= STOP;
        end
        STOP: begin
          tx_out_r <= IDLE_LVL;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          tx_out_r <= IDLE_LVL;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.BUSY   = busy_r;

endmodule
